// File: rtl/bp_pkg.sv
// Shared definitions for the branch-prediction tables.
package bp_pkg;

    localparam logic [6:0]  BRANCH_OPCODE   = 7'b1100011;

    localparam int unsigned DEFAULT_IDX_W   = 10;
    localparam int unsigned DEFAULT_HIST_W  = 10;
    localparam int unsigned DEFAULT_CTR_W   = 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } init_state_t;

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch-side lookup and resolve-side update bundle for the gshare predictor.
interface gshare_predictor_if #(
    parameter int unsigned IDX_W  = bp_pkg::DEFAULT_IDX_W,
    parameter int unsigned HIST_W = bp_pkg::DEFAULT_HIST_W
);
    logic              ready;
    logic              pred_req;
    logic [IDX_W-1:0]  pred_pc;
    logic              pred_valid;
    logic              pred_taken;
    logic [IDX_W-1:0]  pred_idx;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_taken;
    logic [HIST_W-1:0] ghr;

    modport master (
        input  ready, pred_valid, pred_taken, pred_idx, ghr,
        output pred_req, pred_pc, upd_valid, upd_idx, upd_taken
    );

    modport slave (
        output ready, pred_valid, pred_taken, pred_idx, ghr,
        input  pred_req, pred_pc, upd_valid, upd_idx, upd_taken
    );
endinterface

// File: rtl/sat_counter_update.sv
// Saturating up/down counter step, shared by direction and chooser tables.
module sat_counter_update #(
    parameter int unsigned CTR_W = bp_pkg::DEFAULT_CTR_W
) (
    input  logic [CTR_W-1:0] old_ctr,
    input  logic             taken,
    output logic [CTR_W-1:0] new_ctr
);

    // Move toward taken/not-taken, clamping at both ends.
    always_comb begin
        new_ctr = old_ctr;
        if (taken) begin
            if (old_ctr != '1) new_ctr = old_ctr + CTR_W'(1);
        end else begin
            if (old_ctr != '0) new_ctr = old_ctr - CTR_W'(1);
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: PC XOR global history indexes a table
// of saturating counters; table is swept to INIT_CTR after every reset.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned      IDX_W    = DEFAULT_IDX_W,
    parameter int unsigned      HIST_W   = DEFAULT_HIST_W,
    parameter int unsigned      CTR_W    = DEFAULT_CTR_W,
    parameter logic [CTR_W-1:0] INIT_CTR = CTR_W'((1 << CTR_W) - 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    gshare_predictor_if.slave  bp
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    init_state_t       state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HIST_W-1:0] ghr_q;
    logic              pred_valid_q;
    logic              pred_taken_q;
    logic [IDX_W-1:0]  pred_idx_q;

    logic [CTR_W-1:0]  mem [DEPTH];

    logic              running;
    logic              upd_en;
    logic [CTR_W-1:0]  upd_old;
    logic [CTR_W-1:0]  upd_new;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [CTR_W-1:0]  wr_data;
    logic [IDX_W-1:0]  lk_idx;
    logic [CTR_W-1:0]  lk_ctr;
    logic [HIST_W:0]   ghr_shift;

    assign running = (state_q == RUN);
    assign upd_en  = running & bp.upd_valid;
    assign upd_old = mem[bp.upd_idx];

    sat_counter_update #(.CTR_W(CTR_W)) u_sat (
        .old_ctr (upd_old),
        .taken   (bp.upd_taken),
        .new_ctr (upd_new)
    );

    // Init sweep sequencing: walk every entry once, then stay in RUN.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == INIT) begin
            ptr_d = ptr_q + IDX_W'(1);
            if (ptr_q == '1) state_d = RUN;
        end
    end

    // Sweep state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Single table write port: the sweep owns it during INIT, updates in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bp.upd_idx;
        wr_data = upd_new;
        if (state_q == INIT) begin
            wr_en   = 1'b1;
            wr_addr = ptr_q;
            wr_data = INIT_CTR;
        end else if (upd_en) begin
            wr_en   = 1'b1;
        end
    end

    // Counter table storage, no reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Lookup uses pre-update history; same-index update is bypassed outside the array.
    always_comb begin
        lk_idx = bp.pred_pc ^ IDX_W'(ghr_q);
        lk_ctr = mem[lk_idx];
        if (upd_en && (bp.upd_idx == lk_idx)) lk_ctr = upd_new;
    end

    // Registered prediction response; idx/taken hold when no request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
        end else if (running) begin
            pred_valid_q <= bp.pred_req;
            if (bp.pred_req) begin
                pred_idx_q   <= lk_idx;
                pred_taken_q <= lk_ctr[CTR_W-1];
            end
        end else begin
            pred_valid_q <= 1'b0;
        end
    end

    assign ghr_shift = {ghr_q, bp.upd_taken};

    // Non-speculative global history, shifted only by resolved branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (upd_en) begin
            ghr_q <= ghr_shift[HIST_W-1:0];
        end
    end

    assign bp.ready      = running;
    assign bp.pred_valid = pred_valid_q;
    assign bp.pred_taken = pred_taken_q;
    assign bp.pred_idx   = pred_idx_q;
    assign bp.ghr        = ghr_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor with default parameters.
module tb_gshare_predictor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ncyc;

    gshare_predictor_if #(.IDX_W(10), .HIST_W(10)) bp ();

    gshare_predictor #(.IDX_W(10), .HIST_W(10), .CTR_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [9:0] pc);
        bp.pred_req = 1'b1;
        bp.pred_pc  = pc;
        step();
        bp.pred_req = 1'b0;
    endtask

    task automatic update(input logic [9:0] idx, input logic t);
        bp.upd_valid = 1'b1;
        bp.upd_idx   = idx;
        bp.upd_taken = t;
        step();
        bp.upd_valid = 1'b0;
    endtask

    // Counts edges until ready, hammering requests/updates that must be ignored.
    task automatic sweep(output int n);
        n = 0;
        bp.pred_req  = 1'b1;
        bp.pred_pc   = 10'h155;
        bp.upd_idx   = 10'h155;
        bp.upd_taken = 1'b1;
        while (!bp.ready && n < 2000) begin
            bp.upd_valid = n[0];
            step();
            n++;
            check("init_pred_valid", 32'(bp.pred_valid), 32'd0);
        end
        bp.pred_req  = 1'b0;
        bp.upd_valid = 1'b0;
    endtask

    initial begin
        bp.pred_req  = 1'b0;
        bp.pred_pc   = '0;
        bp.upd_valid = 1'b0;
        bp.upd_idx   = '0;
        bp.upd_taken = 1'b0;

        // Reset state
        step();
        step();
        check("rst_ready",      32'(bp.ready),      32'd0);
        check("rst_pred_valid", 32'(bp.pred_valid), 32'd0);
        check("rst_pred_taken", 32'(bp.pred_taken), 32'd0);
        check("rst_pred_idx",   32'(bp.pred_idx),   32'd0);
        check("rst_ghr",        32'(bp.ghr),        32'd0);

        // Full sweep length, with updates ignored
        rst_n = 1'b1;
        sweep(ncyc);
        check("sweep_cycles", 32'(ncyc), 32'd1024);
        check("init_ghr", 32'(bp.ghr), 32'd0);

        // First lookup after init sees strongly-taken
        lookup(10'h155);
        check("first_valid", 32'(bp.pred_valid), 32'd1);
        check("first_taken", 32'(bp.pred_taken), 32'd1);
        check("first_idx",   32'(bp.pred_idx),   32'h155);
        step();
        check("idle_valid",  32'(bp.pred_valid), 32'd0);
        check("idle_idx_hold", 32'(bp.pred_idx), 32'h155);

        // Saturation at 0: 11 -> 10 -> 01 -> 00 (ghr stays 0)
        update(10'h005, 1'b0);
        update(10'h005, 1'b0);
        lookup(10'h005);
        check("sat_01_taken", 32'(bp.pred_taken), 32'd0);
        update(10'h005, 1'b0);
        lookup(10'h005);
        check("sat_00_taken", 32'(bp.pred_taken), 32'd0);
        update(10'h005, 1'b0);
        check("sat_ghr0", 32'(bp.ghr), 32'd0);
        // Taken from 00 -> 01 (a wrap to 11 would predict taken here)
        update(10'h005, 1'b1);
        check("sat_ghr1", 32'(bp.ghr), 32'h001);
        lookup(10'h004);
        check("sat_up1_idx",   32'(bp.pred_idx),   32'h005);
        check("sat_up1_taken", 32'(bp.pred_taken), 32'd0);
        update(10'h005, 1'b1);
        check("sat_ghr3", 32'(bp.ghr), 32'h003);
        lookup(10'h006);
        check("sat_up2_idx",   32'(bp.pred_idx),   32'h005);
        check("sat_up2_taken", 32'(bp.pred_taken), 32'd1);

        // Flush history with not-taken updates to 0x3FF (counter ends at 00)
        for (int i = 0; i < 10; i++) update(10'h3FF, 1'b0);
        check("flush_ghr", 32'(bp.ghr), 32'd0);
        lookup(10'h3FF);
        check("flush_3ff_taken", 32'(bp.pred_taken), 32'd0);

        // Indexing: T, NT, T -> ghr 0x005; 0x3F0 ^ 0x005 = 0x3F5
        update(10'h300, 1'b1);
        update(10'h300, 1'b0);
        update(10'h300, 1'b1);
        check("idx_ghr", 32'(bp.ghr), 32'h005);
        lookup(10'h3F0);
        check("idx_pred_idx",   32'(bp.pred_idx),   32'h3F5);
        check("idx_pred_taken", 32'(bp.pred_taken), 32'd1);

        // Bypass: entry 0x010 to 10, ghr -> 0x00A
        update(10'h010, 1'b0);
        check("byp_ghr_a", 32'(bp.ghr), 32'h00A);
        lookup(10'h01A);
        check("byp_pre_idx",   32'(bp.pred_idx),   32'h010);
        check("byp_pre_taken", 32'(bp.pred_taken), 32'd1);
        // Same-cycle lookup and not-taken update on 0x010: 10 -> 01
        bp.pred_req  = 1'b1;
        bp.pred_pc   = 10'h01A;
        bp.upd_valid = 1'b1;
        bp.upd_idx   = 10'h010;
        bp.upd_taken = 1'b0;
        step();
        bp.pred_req  = 1'b0;
        bp.upd_valid = 1'b0;
        check("byp_valid", 32'(bp.pred_valid), 32'd1);
        check("byp_idx",   32'(bp.pred_idx),   32'h010);
        check("byp_taken", 32'(bp.pred_taken), 32'd0);
        check("byp_ghr",   32'(bp.ghr),        32'h014);

        // Reset mid-sweep at cycle 500, then a full 1024-cycle sweep
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) step();
        check("mid_not_ready", 32'(bp.ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ghr",   32'(bp.ghr),   32'd0);
        check("mid_rst_ready", 32'(bp.ready), 32'd0);
        step();
        rst_n = 1'b1;
        sweep(ncyc);
        check("resweep_cycles", 32'(ncyc), 32'd1024);
        check("resweep_ghr",    32'(bp.ghr), 32'd0);

        // Previously weakened entries are back to strongly-taken
        lookup(10'h010);
        check("stale_010_taken", 32'(bp.pred_taken), 32'd1);
        lookup(10'h3FF);
        check("stale_3ff_taken", 32'(bp.pred_taken), 32'd1);
        // 11 -> 10 still predicts taken; one more NT must reach 01
        update(10'h005, 1'b0);
        update(10'h005, 1'b0);
        lookup(10'h005);
        check("stale_005_taken", 32'(bp.pred_taken), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
